// File: rtl/kernel_launch_ctrl.sv
// Launch controller for one HLS kernel run: loads N host words into a shared
// single-port SRAM, then hands the port to the kernel and captures ap_return.
module kernel_launch_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          cmd_start,
  input  logic [31:0]   cmd_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  output logic          busy,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic [1:0]    err,
  output logic [31:0]   k_n,
  output logic          k_ap_start,
  input  logic          k_ap_done,
  input  logic          k_ap_idle,
  input  logic [DW-1:0] k_ap_return,
  input  logic [AW-1:0] k_address0,
  input  logic [DW-1:0] k_d0,
  input  logic          k_ce0,
  input  logic          k_we0,
  output logic [DW-1:0] k_q0,
  output logic [AW-1:0] mem_address0,
  output logic [DW-1:0] mem_d0,
  output logic          mem_ce0,
  output logic          mem_we0,
  input  logic [DW-1:0] mem_q0
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   wdog;
  logic          beat, last_beat, timeout_hit, bad_len;

  // kernel idle is informational only
  logic unused_idle;
  assign unused_idle = k_ap_idle;

  assign k_q0        = mem_q0;
  assign beat        = (state == S_LOAD) && ld_valid;
  assign last_beat   = beat && (32'(cnt) == k_n - 32'd1);
  assign timeout_hit = (TIMEOUT != 0) && (wdog == TO_LAST);
  assign bad_len     = cmd_n > 32'(DEPTH);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (cmd_start && !bad_len) state_nx = (cmd_n == 32'd0) ? S_RUN : S_LOAD;
      S_LOAD: if (last_beat) state_nx = S_RUN;
      // a done in the timeout cycle still counts as a completed run
      S_RUN: begin
        if (k_ap_done)        state_nx = S_DONE;
        else if (timeout_hit) state_nx = S_IDLE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready     = 1'b0;
    mem_address0 = '0;
    mem_d0       = '0;
    mem_ce0      = 1'b0;
    mem_we0      = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready     = 1'b1;
        mem_address0 = AW'(cnt);
        mem_d0       = ld_data;
        mem_ce0      = ld_valid;
        mem_we0      = ld_valid;
      end
      S_RUN: begin
        mem_address0 = k_address0;
        mem_d0       = k_d0;
        mem_ce0      = k_ce0;
        mem_we0      = k_we0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      busy         <= 1'b0;
      k_ap_start   <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      err          <= 2'd0;
      k_n          <= 32'd0;
      cnt          <= '0;
      wdog         <= 32'd0;
    end else begin
      busy         <= state_nx != S_IDLE;
      k_ap_start   <= state_nx == S_RUN;
      result_valid <= state_nx == S_DONE;
      case (state)
        S_IDLE: begin
          wdog <= 32'd0;
          if (cmd_start) begin
            if (bad_len) err <= 2'd1;
            else begin
              k_n <= cmd_n;
              cnt <= '0;
              err <= 2'd0;
            end
          end
        end
        S_LOAD: begin
          wdog <= 32'd0;
          if (beat) cnt <= cnt + CW'(1);
        end
        S_RUN: begin
          wdog <= wdog + 32'd1;
          if (k_ap_done)        result <= k_ap_return;
          else if (timeout_hit) err    <= 2'd2;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Directed bench: SRAM model plus a kernel model (sum / hang / done-at-20).
module tb_kernel_launch_ctrl;
  localparam int DW = 32, AW = 32, DEPTH = 16, TIMEOUT = 20;

  logic          ap_clk = 1'b0, ap_rst = 1'b1;
  logic          cmd_start, ld_valid, ld_ready, busy, result_valid;
  logic [31:0]   cmd_n, k_n;
  logic [DW-1:0] ld_data, result, k_ap_return, k_d0, k_q0, mem_d0, mem_q0;
  logic [1:0]    err;
  logic          k_ap_start, k_ap_done, k_ap_idle, k_ce0, k_we0, mem_ce0, mem_we0;
  logic [AW-1:0] k_address0, mem_address0;

  int total = 0, bad = 0, start_gap = 0, kmode = 0;

  always #5 ap_clk = ~ap_clk;

  kernel_launch_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .cmd_start(cmd_start), .cmd_n(cmd_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .busy(busy),
    .result(result), .result_valid(result_valid), .err(err), .k_n(k_n),
    .k_ap_start(k_ap_start), .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
    .k_ap_return(k_ap_return), .k_address0(k_address0), .k_d0(k_d0),
    .k_ce0(k_ce0), .k_we0(k_we0), .k_q0(k_q0), .mem_address0(mem_address0),
    .mem_d0(mem_d0), .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_q0(mem_q0)
  );

  // single-port SRAM, one-cycle read latency, with a write-address log
  logic [DW-1:0] sram [0:DEPTH-1];
  logic [31:0]   wlog [$];
  always @(posedge ap_clk) begin
    if (mem_ce0) begin
      if (mem_we0) begin
        sram[mem_address0[3:0]] <= mem_d0;
        wlog.push_back(mem_address0);
      end
      mem_q0 <= sram[mem_address0[3:0]];
    end
  end

  // kernel: mode 0 sums SRAM[0..k_n-1], 1 never finishes, 2 finishes in run cycle 20
  logic        kst;
  logic [31:0] ki, acc;
  logic [1:0]  rdv;
  int          kc;
  always @(posedge ap_clk) begin
    logic [31:0] acc_n;
    if (ap_rst) begin
      kst <= 1'b0; ki <= 0; acc <= 0; rdv <= 2'b00; kc <= 0;
      k_ap_done <= 1'b0; k_ap_return <= '0; k_ce0 <= 1'b0; k_we0 <= 1'b0;
      k_address0 <= '0; k_d0 <= '0;
    end else begin
      k_ap_done <= 1'b0;
      kc <= k_ap_start ? kc + 1 : 0;
      if (kmode == 2 && k_ap_start && kc == 18) begin
        k_ap_done <= 1'b1;
        k_ap_return <= 32'hBEEF;
      end
      if (kmode == 0) begin
        acc_n = rdv[1] ? acc + k_q0 : acc;
        acc <= acc_n;
        rdv[1] <= rdv[0];
        if (!kst) begin
          rdv[0] <= 1'b0;
          if (k_ap_start && !k_ap_done) begin kst <= 1'b1; ki <= 0; acc <= 0; end
        end else if (ki < k_n) begin
          k_ce0 <= 1'b1; k_address0 <= ki; ki <= ki + 1; rdv[0] <= 1'b1;
        end else begin
          k_ce0 <= 1'b0; rdv[0] <= 1'b0;
          if (rdv == 2'b00) begin k_ap_done <= 1'b1; k_ap_return <= acc_n; kst <= 1'b0; end
        end
      end
    end
  end

  task automatic tick;
    @(posedge ap_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [31:0] n);
    cmd_start = 1'b1; cmd_n = n;
    tick;
    cmd_start = 1'b0;
  endtask

  task automatic load(input int n, input logic [31:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = base + 32'(i);
      tick;
      if (gaps) begin ld_valid = 1'b0; tick; end
    end
    ld_valid = 1'b0;
  endtask

  // waits for result_valid, checking that ap_start stays high until then
  task automatic wait_rv(output int cyc);
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (result_valid) begin cyc = i; break; end
      if (!k_ap_start) start_gap++;
      tick;
    end
  endtask

  initial begin
    int cyc, err_cnt, rv_seen;
    cmd_start = 0; cmd_n = 0; ld_valid = 0; ld_data = 0; k_ap_idle = 1'b1;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_start", k_ap_start, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_ce_we", {mem_ce0, mem_we0}, 0);
    chk("rst_addr", mem_address0, 0);
    chk("rst_regs", {result, k_n, 30'd0, err}, 0);
    ap_rst = 1'b0;
    tick;

    // back-to-back load of 1..10, sum kernel
    wlog.delete();
    start_cmd(10);
    chk("t1_k_n", k_n, 10);
    chk("t1_ld_ready", ld_ready, 1);
    chk("t1_busy", busy, 1);
    load(10, 1, 0);
    chk("t1_run_start", k_ap_start, 1);
    chk("t1_run_ld_ready", ld_ready, 0);
    start_gap = 0;
    wait_rv(cyc);
    chk("t1_rv_seen", cyc >= 0, 1);
    chk("t1_start_held", start_gap, 0);
    chk("t1_result", result, 55);
    chk("t1_err", err, 0);
    chk("t1_start_drop", k_ap_start, 0);
    tick;
    chk("t1_rv_pulse", result_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_nwr", wlog.size(), 10);
    err_cnt = 0;
    foreach (wlog[i]) if (wlog[i] != 32'(i)) err_cnt++;
    chk("t1_wr_order", err_cnt, 0);
    chk("t1_sram0", sram[0], 1);
    chk("t1_sram9", sram[9], 10);

    // same load with ld_valid gaps
    wlog.delete();
    start_cmd(10);
    load(10, 1, 1);
    chk("t2_nwr", wlog.size(), 10);
    err_cnt = 0;
    foreach (wlog[i]) if (wlog[i] != 32'(i)) err_cnt++;
    chk("t2_wr_order", err_cnt, 0);
    wait_rv(cyc);
    chk("t2_rv_seen", cyc >= 0, 1);
    chk("t2_result", result, 55);
    tick;

    // zero length: straight to RUN; stray cmd/ld inputs during RUN ignored
    wlog.delete();
    start_cmd(0);
    chk("t3_start", k_ap_start, 1);
    chk("t3_ld_ready", ld_ready, 0);
    chk("t3_k_n", k_n, 0);
    ld_valid = 1'b1; cmd_start = 1'b1; cmd_n = 17;
    tick;
    cmd_start = 1'b0;
    chk("t3_ld_ready_run", ld_ready, 0);
    wait_rv(cyc);
    ld_valid = 1'b0;
    chk("t3_rv_seen", cyc >= 0, 1);
    chk("t3_result", result, 0);
    chk("t3_err", err, 0);
    chk("t3_nwr", wlog.size(), 0);
    tick;

    // bad lengths, then a good command clears err
    start_cmd(DEPTH + 1);
    chk("t4_err1", err, 1);
    chk("t4_busy", busy, 0);
    tick;
    chk("t4_err_sticky", err, 1);
    start_cmd(32'h0001_0004);
    chk("t4_err_wide", err, 1);
    chk("t4_busy_wide", busy, 0);
    start_cmd(4);
    chk("t4_err_clr", err, 0);
    chk("t4_k_n", k_n, 4);
    load(4, 5, 0);
    wait_rv(cyc);
    chk("t4_result", result, 26);
    tick;

    // watchdog expiry
    kmode = 1;
    start_cmd(0);
    cyc = 0; rv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (result_valid) rv_seen++;
      tick; cyc++;
    end
    chk("t5_to_cycles", cyc, 20);
    chk("t5_err", err, 2);
    chk("t5_start", k_ap_start, 0);
    chk("t5_result_kept", result, 26);
    chk("t5_no_rv", rv_seen + int'(result_valid), 0);

    // done on the last allowed cycle wins over timeout
    kmode = 2;
    start_cmd(0);
    wait_rv(cyc);
    chk("t5b_cycles", cyc, 20);
    chk("t5b_result", result, 32'hBEEF);
    chk("t5b_err", err, 0);
    tick;

    // reset in the middle of a load
    kmode = 0;
    wlog.delete();
    start_cmd(10);
    load(5, 100, 0);
    ap_rst = 1'b1;
    tick;
    chk("t6_busy", busy, 0);
    chk("t6_ld_ready", ld_ready, 0);
    chk("t6_regs", {result, k_n, 30'd0, err}, 0);
    chk("t6_ce", mem_ce0, 0);
    ap_rst = 1'b0;
    chk("t6_nwr", wlog.size(), 5);
    chk("t6_sram0", sram[0], 100);
    chk("t6_sram4", sram[4], 104);
    tick;
    start_cmd(10);
    load(10, 1, 0);
    wait_rv(cyc);
    chk("t6_rv_seen", cyc >= 0, 1);
    chk("t6_result", result, 55);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kernel_launch_ctrl.md
Name: kernel_launch_ctrl

Overview:
Sequences one HLS kernel run (ap_start/ap_done/ap_return protocol) against a single-port SRAM that both a host loader and the kernel need. On a host command it streams N words into the SRAM at addresses 0..N-1 and drives kernel length N. It then hands the SRAM port to the kernel, holds ap_start until ap_done, and captures ap_return. It sits between host, kernel and SRAM instance, replacing ad-hoc bench muxing of the SRAM port.

Parameters:
DW, 32, data width of SRAM words and ap_return
AW, 32, SRAM address port width
DEPTH, 1024, SRAM words; upper bound on N
TIMEOUT, 65535, max cycles in RUN before abort; 0 disables watchdog

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  synchronous active-high reset
cmd_start  in  1  pulse: begin load+run; sampled only in IDLE
cmd_n  in  32  word count N; sampled with cmd_start
ld_valid  in  1  host load word valid
ld_ready  out  1  controller accepts load word
ld_data  in  DW  load word
busy  out  1  state != IDLE
result  out  DW  captured ap_return
result_valid  out  1  one-cycle pulse, result updated
err  out  2  0 none, 1 bad length, 2 timeout; sticky until next accepted cmd_start
k_n  out  32  latched N to kernel
k_ap_start  out  1  kernel start
k_ap_done  in  1  kernel done
k_ap_idle  in  1  kernel idle (status only)
k_ap_return  in  DW  kernel result
k_address0  in  AW  kernel SRAM address
k_d0  in  DW  kernel SRAM write data
k_ce0  in  1  kernel SRAM enable
k_we0  in  1  kernel SRAM write enable
k_q0  out  DW  SRAM read data to kernel (= mem_q0, always)
mem_address0  out  AW  SRAM address
mem_d0  out  DW  SRAM write data
mem_ce0  out  1  SRAM enable
mem_we0  out  1  SRAM write enable
mem_q0  in  DW  SRAM read data

Behaviour:
- Reset: state IDLE; ld_ready, busy, result_valid, k_ap_start, mem_ce0, mem_we0 = 0; result, err, k_n, load counter = 0; mem_address0 = 0.
- FSM states IDLE, LOAD, RUN, DONE; all control outputs registered except SRAM port mux and ld_ready (combinational from state).
- IDLE: cmd_start=1 and cmd_n > DEPTH -> err<=1, stay IDLE. cmd_start=1, 1<=cmd_n<=DEPTH -> k_n<=cmd_n, cnt<=0, err<=0, go LOAD. cmd_start=1, cmd_n=0 -> k_n<=0, err<=0, go RUN (no load).
- LOAD: ld_ready=1. Beat accepted when ld_valid&ld_ready: mem_address0=cnt, mem_d0=ld_data, mem_ce0=mem_we0=1, cnt++. Beat with cnt==N-1 -> RUN next cycle. ld_valid gaps allowed; no writes when ld_valid=0 (ce/we=0).
- RUN: k_ap_start=1 from first RUN cycle, held until ap_done observed. SRAM port passes through k_address0/k_d0/k_ce0/k_we0. On k_ap_done=1: result<=k_ap_return, k_ap_start<=0, go DONE. Watchdog counter counts RUN cycles; reaching TIMEOUT (TIMEOUT!=0) without ap_done -> err<=2, k_ap_start<=0, go IDLE, result unchanged, no result_valid.
- DONE: result_valid=1 exactly one cycle; next state IDLE.
- Outside LOAD/RUN: mem_ce0=mem_we0=0, mem_address0=0; kernel ce/we ignored.
- cmd_start outside IDLE ignored; ld_valid outside LOAD ignored (ld_ready=0).
- ap_done and timeout in same cycle: ap_done wins (result captured, err stays 0).
- Reset asserted in any state, including mid-LOAD/RUN: next cycle matches reset values; partially written SRAM contents not cleared.
- cnt width clog2(DEPTH)+1; N compared full 32-bit, no truncation.

Test Plan:
- Load 1..10 back-to-back, cmd_n=10, kernel = Sum model -> SRAM[0..9]=1..10, k_n=10, k_ap_start high from RUN entry to ap_done, result=55, result_valid one cycle, err=0.
- Same load with ld_valid toggling every other cycle -> exactly 10 writes, addresses 0..9 in order, result 55.
- cmd_n=0 -> no SRAM writes, ld_ready never high, straight RUN; kernel returns 0 -> result=0, result_valid pulse.
- cmd_n=DEPTH+1 -> err=1 next cycle, busy stays 0; following cmd_start with cmd_n=4 clears err to 0.
- TIMEOUT=20, kernel never asserts ap_done -> after 20 RUN cycles k_ap_start=0, err=2, busy=0, no result_valid; ap_done on cycle 20 instead -> result captured, err=0.
- ap_rst pulsed after 5 of 10 load beats -> all outputs at reset values next cycle, SRAM[0..4] retained; new cmd runs normally.
